audio_adc_rx: RTL and testbench

- Serial audio capture path: the receive-side counterpart of the DAC serializer.
- Acts as frame master for the codec ADC. Generates a one-cycle frame-sync pulse every FRAME_DIV clocks, then samples 32 serial bits MSB-first.
- Presents each assembled word on a registered valid/ready output port.
- Sits between the codec ADC pins and the audio DSP/FIFO logic.

---
 rtl/audio_adc_rx.sv | 166 ++++++++++++++++
 tb/tb_audio_adc_rx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_adc_rx.sv
// Serial audio ADC receiver: frame master that pulses audio_adclr every FRAME_DIV
// clocks and assembles a 32-bit MSB-first word. Optional macro AUDIO_RX_OVF_CNT_EN adds overrun_cnt.
module audio_adc_rx #(
  parameter int unsigned FRAME_DIV  = 251,
  parameter int unsigned DATA_DELAY = 2
) (
  input  logic        clock_12Mhz,
  input  logic        reset_n,
  output logic        audio_adclr,
  input  logic        audio_adcdat,
  output logic [31:0] audio_data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        overrun,
  input  logic        overrun_clr
`ifdef AUDIO_RX_OVF_CNT_EN
  ,
  output logic [7:0]  overrun_cnt
`endif
);

  localparam int unsigned CW = $clog2(FRAME_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_DIV - 1);
  localparam logic [2:0] DLY_INIT = 3'(DATA_DELAY - 1);

  generate
    if (FRAME_DIV < DATA_DELAY + 33) begin : g_bad_frame_div
      $error("audio_adc_rx: FRAME_DIV must be >= DATA_DELAY+33");
    end
    if (DATA_DELAY < 1 || DATA_DELAY > 8) begin : g_bad_data_delay
      $error("audio_adc_rx: DATA_DELAY must be in 1..8");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, DELAY, SHIFT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          adclr_q, adclr_d;
  logic [2:0]    dly_q, dly_d;
  logic [4:0]    bit_q, bit_d;
  logic [31:0]   shift_q, shift_d;
  logic [31:0]   data_q, data_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;
  logic          word_done;
  logic          ovr_ev;
  logic [31:0]   next_word;

  always_ff @(posedge clock_12Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      adclr_q <= 1'b0;
      dly_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adclr_q <= adclr_d;
      dly_q   <= dly_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    adclr_d   = (cnt_q == CNT_LAST);
    state_d   = state_q;
    dly_d     = dly_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    word_done = 1'b0;
    next_word = {shift_q[30:0], audio_adcdat};

    // The edge leaving DELAY already samples the MSB, so bit_q counts the bits still to come.
    unique case (state_q)
      IDLE: begin
        if (adclr_d) begin
          state_d = DELAY;
          dly_d   = DLY_INIT;
        end
      end
      DELAY: begin
        if (dly_q == '0) begin
          state_d = SHIFT;
          shift_d = next_word;
          bit_d   = 5'd30;
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      SHIFT: begin
        shift_d = next_word;
        if (bit_q == '0) begin
          word_done = 1'b1;
          state_d   = IDLE;
        end else begin
          bit_d = bit_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_ev  = word_done & valid_q & ~data_ready;
    if (word_done) begin
      data_d  = next_word;
      valid_d = 1'b1;
    end else if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end
    if (ovr_ev) begin
      ovr_d = 1'b1;
    end else if (overrun_clr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

`ifdef AUDIO_RX_OVF_CNT_EN
  logic [7:0] ocnt_q, ocnt_d;

  always_ff @(posedge clock_12Mhz or negedge reset_n) begin
    if (!reset_n) begin
      ocnt_q <= '0;
    end else begin
      ocnt_q <= ocnt_d;
    end
  end

  // An overrun coinciding with a clear restarts the count at 1.
  always_comb begin
    ocnt_d = ocnt_q;
    if (ovr_ev) begin
      if (overrun_clr) begin
        ocnt_d = 8'd1;
      end else if (ocnt_q != '1) begin
        ocnt_d = ocnt_q + 1'b1;
      end
    end else if (overrun_clr) begin
      ocnt_d = '0;
    end
  end

  assign overrun_cnt = ocnt_q;
`endif

  assign audio_adclr    = adclr_q;
  assign audio_data_out = data_q;
  assign data_valid     = valid_q;
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_audio_adc_rx.sv
// Bench for audio_adc_rx: two instances (251/2 and 40/1) against an edge-arithmetic reference model.
module tb_audio_adc_rx;

  localparam int FD0 = 251;
  localparam int DD0 = 2;
  localparam int FD1 = 40;
  localparam int DD1 = 1;

  int FDv[2];
  int DDv[2];

  logic        clk;
  logic        rst_n;
  logic [1:0]  adcdat;
  logic        ready0, ready1, clr0, clr1;
  logic [1:0]  adclr_o, valid_o, ovr_o;
  logic [1:0][31:0] dout;
  logic [1:0][7:0]  ocnt;

  int n_cmp = 0;
  int n_bad = 0;

  int          m[2];
  logic [31:0] acc[2];
  logic [31:0] e_data[2];
  logic        e_v[2], e_ov[2], e_adclr[2];
  int          e_cnt[2];

  logic [31:0] tx_dir[2];
  logic [31:0] tx_cur[2];
  logic        rand_mode[2];
  logic        rand1;

  audio_adc_rx #(.FRAME_DIV(FD0), .DATA_DELAY(DD0)) u_dut0 (
    .clock_12Mhz(clk), .reset_n(rst_n), .audio_adclr(adclr_o[0]), .audio_adcdat(adcdat[0]),
    .audio_data_out(dout[0]), .data_valid(valid_o[0]), .data_ready(ready0),
    .overrun(ovr_o[0]), .overrun_clr(clr0)
`ifdef AUDIO_RX_OVF_CNT_EN
    , .overrun_cnt(ocnt[0])
`endif
  );

  audio_adc_rx #(.FRAME_DIV(FD1), .DATA_DELAY(DD1)) u_dut1 (
    .clock_12Mhz(clk), .reset_n(rst_n), .audio_adclr(adclr_o[1]), .audio_adcdat(adcdat[1]),
    .audio_data_out(dout[1]), .data_valid(valid_o[1]), .data_ready(ready1),
    .overrun(ovr_o[1]), .overrun_clr(clr1)
`ifdef AUDIO_RX_OVF_CNT_EN
    , .overrun_cnt(ocnt[1])
`endif
  );

`ifndef AUDIO_RX_OVF_CNT_EN
  assign ocnt = '0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic goto(input int t);
    int b;
    b = 0;
    while (m[0] < t) begin
      @(negedge clk);
      b++;
      if (b > 100000) begin
        $display("FAIL goto(%0d): edge budget expired", t);
        $fatal(1, "timeout");
      end
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: every rule is expressed as a function of the edge number since reset release.
  initial begin
    FDv[0] = FD0; FDv[1] = FD1;
    DDv[0] = DD0; DDv[1] = DD1;
    for (int i = 0; i < 2; i++) begin
      m[i] = 0; acc[i] = '0; e_data[i] = '0; e_v[i] = 0; e_ov[i] = 0; e_adclr[i] = 0; e_cnt[i] = 0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        logic rdy, clr, ev, lsb;
        int off;
        rdy = (i == 0) ? ready0 : ready1;
        clr = (i == 0) ? clr0 : clr1;
        if (!rst_n) begin
          m[i] = 0; acc[i] = '0; e_data[i] = '0; e_v[i] = 0; e_ov[i] = 0; e_adclr[i] = 0; e_cnt[i] = 0;
        end else begin
          m[i]++;
          off = m[i] - DDv[i];
          if (off >= FDv[i] && (off % FDv[i]) < 32) acc[i] = {acc[i][30:0], adcdat[i]};
          lsb = (off >= FDv[i]) && ((off % FDv[i]) == 31);
          ev = 0;
          if (lsb) begin
            ev = e_v[i] && !rdy;
            e_data[i] = acc[i];
            e_v[i] = 1;
          end else if (e_v[i] && rdy) begin
            e_v[i] = 0;
          end
          if (ev) e_ov[i] = 1;
          else if (clr) e_ov[i] = 0;
          if (ev) e_cnt[i] = clr ? 1 : ((e_cnt[i] == 255) ? 255 : e_cnt[i] + 1);
          else if (clr) e_cnt[i] = 0;
          e_adclr[i] = (m[i] >= FDv[i]) && ((m[i] % FDv[i]) == 0);
        end
      end
      #1;
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("adclr%0d", i), 32'(adclr_o[i]), 32'(e_adclr[i]));
        chk($sformatf("data%0d", i), dout[i], e_data[i]);
        chk($sformatf("valid%0d", i), 32'(valid_o[i]), 32'(e_v[i]));
        chk($sformatf("overrun%0d", i), 32'(ovr_o[i]), 32'(e_ov[i]));
`ifdef AUDIO_RX_OVF_CNT_EN
        chk($sformatf("ovcnt%0d", i), 32'(ocnt[i]), 32'(e_cnt[i]));
`endif
      end
    end
  end

  // Codec model: drives the frame word in its sampling window, random noise elsewhere.
  initial begin
    adcdat = '0;
    tx_cur[0] = '0;
    tx_cur[1] = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        int off;
        off = m[i] + 1 - DDv[i];
        if (rst_n && off >= FDv[i] && (off % FDv[i]) < 32) begin
          if ((off % FDv[i]) == 0) tx_cur[i] = rand_mode[i] ? $urandom : tx_dir[i];
          adcdat[i] = tx_cur[i][31 - (off % FDv[i])];
        end else begin
          adcdat[i] = 1'($urandom);
        end
      end
    end
  end

  initial begin
    ready1 = 0;
    clr1 = 0;
    forever begin
      @(negedge clk);
      if (rand1) begin
        ready1 = ($urandom % 2) == 1;
        clr1 = ($urandom % 8) == 0;
      end
    end
  end

  initial begin
    rst_n = 0; ready0 = 0; clr0 = 0; rand1 = 0;
    rand_mode[0] = 0; rand_mode[1] = 0;
    tx_dir[0] = 32'hA5C3_0F96;
    tx_dir[1] = 32'hFFFF_0000;
    repeat (3) @(negedge clk);
    chk("rst_data0", dout[0], 32'h0);
    chk("rst_valid0", 32'(valid_o[0]), 32'h0);
    rst_n = 1;

    goto(40);   chk("lit_adclr1_40", 32'(adclr_o[1]), 32'h1);
    goto(41);   chk("lit_adclr1_41", 32'(adclr_o[1]), 32'h0);
    goto(72);   chk("lit_word1", dout[1], 32'hFFFF_0000);
                chk("lit_valid1", 32'(valid_o[1]), 32'h1);
    rand_mode[1] = 1; rand1 = 1;
    goto(80);   chk("lit_adclr1_80", 32'(adclr_o[1]), 32'h1);

    goto(250);  chk("lit_adclr0_250", 32'(adclr_o[0]), 32'h0);
    goto(251);  chk("lit_adclr0_251", 32'(adclr_o[0]), 32'h1);
    goto(252);  chk("lit_adclr0_252", 32'(adclr_o[0]), 32'h0);
    goto(283);  chk("lit_valid0_283", 32'(valid_o[0]), 32'h0);
                chk("lit_data0_283", dout[0], 32'h0);
    goto(284);  chk("lit_word0_a", dout[0], 32'hA5C3_0F96);
                chk("lit_valid0_284", 32'(valid_o[0]), 32'h1);
    ready0 = 1;
    goto(285);  chk("lit_accept0", 32'(valid_o[0]), 32'h0);
    ready0 = 0;
    tx_dir[0] = 32'h1234_5678;

    goto(502);  chk("lit_adclr0_502", 32'(adclr_o[0]), 32'h1);
    goto(535);  chk("lit_word0_b", dout[0], 32'h1234_5678);
    tx_dir[0] = 32'h9ABC_DEF0;
    goto(753);  chk("lit_adclr0_753", 32'(adclr_o[0]), 32'h1);
    goto(786);  chk("lit_word0_c", dout[0], 32'h9ABC_DEF0);
                chk("lit_ovr0_set", 32'(ovr_o[0]), 32'h1);
                chk("lit_valid0_786", 32'(valid_o[0]), 32'h1);
`ifdef AUDIO_RX_OVF_CNT_EN
                chk("lit_ocnt0_1", 32'(ocnt[0]), 32'h1);
`endif
    clr0 = 1;
    goto(787);  chk("lit_ovr0_clr", 32'(ovr_o[0]), 32'h0);
`ifdef AUDIO_RX_OVF_CNT_EN
                chk("lit_ocnt0_0", 32'(ocnt[0]), 32'h0);
`endif
    clr0 = 0;
    tx_dir[0] = 32'h0F1E_2D3C;
    goto(1036);
    ready0 = 1;
    goto(1037); chk("lit_word0_d", dout[0], 32'h0F1E_2D3C);
                chk("lit_valid0_1037", 32'(valid_o[0]), 32'h1);
                chk("lit_ovr0_1037", 32'(ovr_o[0]), 32'h0);
    ready0 = 0;
    tx_dir[0] = 32'h5A5A_C3C3;

    goto(1272);
    rst_n = 0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("midrst_data%0d", i), dout[i], 32'h0);
      chk($sformatf("midrst_valid%0d", i), 32'(valid_o[i]), 32'h0);
      chk($sformatf("midrst_adclr%0d", i), 32'(adclr_o[i]), 32'h0);
      chk($sformatf("midrst_ovr%0d", i), 32'(ovr_o[i]), 32'h0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    goto(284);  chk("lit_word0_e", dout[0], 32'h5A5A_C3C3);
                chk("lit_valid0_e", 32'(valid_o[0]), 32'h1);

    rand_mode[0] = 1;
    repeat (FD0 * 8) begin
      @(negedge clk);
      ready0 = ($urandom % 3) == 0;
      clr0 = ($urandom % 16) == 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
